// File: rtl/bs_pkg.sv
// Shared types and helpers for the modmul_bs bit-serial datapath.
package bs_pkg;

   typedef enum logic {BS_IDLE, BS_SHIFT} bs_deser_state_t;

   // Bits needed to hold values 0..v-1; used to size every modmul_bs counter.
   function automatic int bs_clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/bs_out_reg.sv
// One-entry valid/ready holding register; drops a new word and flags overrun
// when the held word has not been consumed.
module bs_out_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic [W-1:0] data_o,
   output logic         valid_o,
   output logic         overrun_o
);

   logic [W-1:0] data_q, data_d;
   logic         valid_q, valid_d;
   logic         overrun_q, overrun_d;

   // A consume in the same cycle as a load frees the slot, so the new word goes straight in.
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (load_i) begin
         if (!valid_q || ready_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign overrun_o = overrun_q;

endmodule

// File: rtl/bs_deserializer.sv
// Framed bit-serial to W-bit parallel converter with a valid/ready output.
// Define BS_DESER_MSB_FIRST_EN for MSB-first bit order (default LSB-first).
module bs_deserializer
   import bs_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         s_en,
   input  logic         s_start,
   input  logic         s_bit,
   output logic [W-1:0] m_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic         overrun,
   output logic         frame_err
);

   localparam int CNTW = bs_clog2(W + 1);
   localparam logic [CNTW-1:0] LAST_CNT = CNTW'(W - 1);

   bs_deser_state_t state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [W-1:0]    sr_q, sr_d, sr_shift;
   logic            frame_err_q, frame_err_d;
   logic            complete;

`ifdef BS_DESER_MSB_FIRST_EN
   assign sr_shift = {sr_q[W-2:0], s_bit};
`else
   assign sr_shift = {s_bit, sr_q[W-1:1]};
`endif

   // Stale bits left by an aborted frame are pushed out by the W shifts of the next one.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sr_d        = sr_q;
      frame_err_d = 1'b0;
      complete    = 1'b0;
      unique case (state_q)
         BS_IDLE: begin
            if (s_en && s_start) begin
               state_d = BS_SHIFT;
               cnt_d   = CNTW'(1);
               sr_d    = sr_shift;
            end
         end
         BS_SHIFT: begin
            if (s_en) begin
               sr_d = sr_shift;
               if (s_start) begin
                  frame_err_d = 1'b1;
                  cnt_d       = CNTW'(1);
               end else if (cnt_q == LAST_CNT) begin
                  complete = 1'b1;
                  state_d  = BS_IDLE;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end
         end
         default: state_d = BS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= BS_IDLE;
         cnt_q       <= '0;
         sr_q        <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign frame_err = frame_err_q;

   bs_out_reg #(.W(W)) u_out_reg (
      .clk       (clk),
      .reset     (reset),
      .load_i    (complete),
      .data_i    (sr_shift),
      .ready_i   (m_ready),
      .data_o    (m_data),
      .valid_o   (m_valid),
      .overrun_o (overrun)
   );

endmodule

// File: tb/tb_bs_deserializer.sv
// Scoreboard bench for bs_deserializer (W=8): directed scenarios then random traffic
// against a frame-level reference model.
module tb_bs_deserializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         s_en = 1'b0;
   logic         s_start = 1'b0;
   logic         s_bit = 1'b0;
   logic         m_ready = 1'b0;
   logic [W-1:0] m_data;
   logic         m_valid;
   logic         overrun;
   logic         frame_err;

   int assertCount = 0;
   int failCount = 0;
   bit checking = 1'b0;

   // Reference model: bits of the frame in progress, and whether a word is held.
   int           frameBits[$];
   bit           inFrame = 1'b0;
   bit           modelValid = 1'b0;
   logic [W-1:0] expQ[$];
   bit           expValidPend = 1'b0, expOvrPend = 1'b0, expFePend = 1'b0;
   bit           expValidCur = 1'b0, expOvrCur = 1'b0, expFeCur = 1'b0;

   bs_deserializer #(.W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .s_en      (s_en),
      .s_start   (s_start),
      .s_bit     (s_bit),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [W-1:0] frameToWord();
      logic [W-1:0] w;
      w = '0;
      for (int i = 0; i < W; i++) begin
`ifdef BS_DESER_MSB_FIRST_EN
         if (frameBits[i] != 0) w[W-1-i] = 1'b1;
`else
         if (frameBits[i] != 0) w[i] = 1'b1;
`endif
      end
      return w;
   endfunction

   // Drives one cycle of inputs and predicts what the DUT shows after the coming edge.
   task automatic applyStimulus(input bit rst, input bit en, input bit start, input bit b, input bit rdy);
      bit done;
      logic [W-1:0] word;
      @(posedge clk);
      #1;
      reset   = rst;
      s_en    = en;
      s_start = start;
      s_bit   = b;
      m_ready = rst ? 1'b0 : rdy;
      done = 1'b0;
      word = '0;
      expOvrPend = 1'b0;
      expFePend  = 1'b0;
      if (rst) begin
         frameBits.delete();
         expQ.delete();
         inFrame    = 1'b0;
         modelValid = 1'b0;
      end else begin
         if (en && start) begin
            if (inFrame) expFePend = 1'b1;
            frameBits.delete();
            frameBits.push_back(int'(b));
            inFrame = 1'b1;
         end else if (en && inFrame) begin
            frameBits.push_back(int'(b));
            if (frameBits.size() == W) begin
               done    = 1'b1;
               word    = frameToWord();
               inFrame = 1'b0;
               frameBits.delete();
            end
         end
         if (done) begin
            if (!modelValid || rdy) begin
               expQ.push_back(word);
               modelValid = 1'b1;
            end else begin
               expOvrPend = 1'b1;
            end
         end else if (modelValid && rdy) begin
            modelValid = 1'b0;
         end
      end
      expValidPend = modelValid;
   endtask

   task automatic sendBits(input logic [W-1:0] word, input int first, input int last, input bit rdy);
      logic [W-1:0] w;
      w = word;
      for (int i = first; i <= last; i++) begin
`ifdef BS_DESER_MSB_FIRST_EN
         applyStimulus(1'b0, 1'b1, i == 0, w[W-1-i], rdy);
`else
         applyStimulus(1'b0, 1'b1, i == 0, w[i], rdy);
`endif
      end
   endtask

   task automatic idleCycles(input int n, input bit rdy);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, rdy);
   endtask

   always @(posedge clk) begin
      expValidCur <= expValidPend;
      expOvrCur   <= expOvrPend;
      expFeCur    <= expFePend;
   end

   // Monitor: pulse/valid checks every cycle, data popped from the scoreboard on each transfer.
   always @(negedge clk) begin
      if (checking) begin
         checkOutput("m_valid", 32'(m_valid), 32'(expValidCur));
         checkOutput("overrun", 32'(overrun), 32'(expOvrCur));
         checkOutput("frame_err", 32'(frame_err), 32'(expFeCur));
         if (m_valid && m_ready) begin
            if (expQ.size() == 0) begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL m_data_unexpected: got 0x%0h, expected no word at %0t", m_data, $time);
            end else begin
               checkOutput("m_data", 32'(m_data), 32'(expQ.pop_front()));
            end
         end
      end
   end

   initial begin
      bit en, st, rst;
      // Reset with m_ready low.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checking = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("reset_m_data", 32'(m_data), 32'h0);
      checkOutput("reset_m_valid", 32'(m_valid), 32'h0);

      $display("[TB] single set bit");
      sendBits(8'h01, 0, 7, 1'b1);
      idleCycles(2, 1'b1);

      $display("[TB] gap of three idle cycles mid-word");
      sendBits(8'hA6, 0, 3, 1'b1);
      idleCycles(3, 1'b1);
      sendBits(8'hA6, 4, 7, 1'b1);
      idleCycles(2, 1'b1);

      $display("[TB] restart mid-word");
      sendBits(8'hFF, 0, 4, 1'b1);
      sendBits(8'h5A, 0, 7, 1'b1);
      idleCycles(2, 1'b1);

      $display("[TB] back-to-back with consumer stalled");
      sendBits(8'h11, 0, 7, 1'b0);
      sendBits(8'h22, 0, 7, 1'b0);
      idleCycles(1, 1'b1);
      sendBits(8'h11, 0, 7, 1'b0);
      sendBits(8'h22, 0, 6, 1'b0);
      sendBits(8'h22, 7, 7, 1'b1);
      idleCycles(2, 1'b0);
      idleCycles(1, 1'b1);

      $display("[TB] reset mid-word");
      sendBits(8'h7E, 0, 2, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      sendBits(8'hC3, 0, 7, 1'b1);
      idleCycles(2, 1'b1);

      $display("[TB] random traffic");
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         en  = ($urandom_range(0, 3) != 0);
         st  = inFrame ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 1) == 0);
         applyStimulus(rst, en, st, 1'($urandom), 1'($urandom_range(0, 2) != 0));
      end
      idleCycles(4, 1'b1);
      @(negedge clk);
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
